// File: rtl/ltc2308_scan_ctrl_if.sv
// Signal bundle between the LTC2308 scan controller and its surroundings:
// the fabric-side command/result port plus the four ADC pins.
// slave = the controller; master = everything around it (sample consumer and ADC).
interface ltc2308_scan_ctrl_if #(
  parameter int N_CH   = 8,
  parameter int N_BITS = 12
);
  logic              start;
  logic              run;
  logic [N_CH-1:0]   ch_mask;
  logic              uni;
  logic              busy;
  logic              out_valid;
  logic [2:0]        out_ch;
  logic [N_BITS-1:0] out_data;
  logic              adc_convst;
  logic              adc_sck;
  logic              adc_sdi;
  logic              adc_sdo;

  modport slave (
    input  start, run, ch_mask, uni, adc_sdo,
    output busy, out_valid, out_ch, out_data, adc_convst, adc_sck, adc_sdi
  );

  modport master (
    output start, run, ch_mask, uni, adc_sdo,
    input  busy, out_valid, out_ch, out_data, adc_convst, adc_sck, adc_sdi
  );
endinterface

// File: rtl/ltc2308_scan_ctrl.sv
// SPI scan controller for the LTC2308 8-channel 12-bit ADC.
// Sweeps the enabled channels (once or continuously), drives CONVST/SCK/SDI,
// shifts in SDO and tags every result with the channel it belongs to. The chip
// returns the conversion configured one frame earlier, so the channel sent in
// the previous frame is carried along and an extra flush frame ends each sweep.
// All pin and result outputs come straight from flops.
module ltc2308_scan_ctrl #(
  parameter int N_CH       = 8,
  parameter int N_BITS     = 12,
  parameter int SCK_HALF   = 2,
  parameter int CONVST_CYC = 2,
  parameter int CONV_CYC   = 80,
  parameter int FRAME_CYC  = 100
) (
  input  logic clk,
  input  logic rst,
  ltc2308_scan_ctrl_if.slave bus
);

  localparam int CH_W   = 3;
  localparam int FCNT_W = $clog2(CONV_CYC + 2 * N_BITS * SCK_HALF + FRAME_CYC + 2);
  localparam int PCNT_W = $clog2(2 * SCK_HALF + 1);
  localparam int BCNT_W = $clog2(N_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    CONV_WAIT,
    SHIFT,
    GAP
  } state_t;

  state_t            state, state_n;
  logic [FCNT_W-1:0] fcnt, fcnt_n;
  logic [PCNT_W-1:0] pcnt, pcnt_n;
  logic [BCNT_W-1:0] bcnt, bcnt_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic [N_CH-1:0]   mask, mask_n;
  logic              uni_l, uni_n;
  logic              cont, cont_n;
  logic              flush, flush_n;
  logic [CH_W-1:0]   prev_ch, prev_ch_n;
  logic              prev_valid, prev_valid_n;
  logic [N_BITS-1:0] shreg, shreg_n;
  logic              convst, convst_n;
  logic              sck, sck_n;
  logic              sdi, sdi_n;
  logic              busy, busy_n;
  logic              out_valid, out_valid_n;
  logic [CH_W-1:0]   out_ch, out_ch_n;
  logic [N_BITS-1:0] out_data, out_data_n;

  logic [5:0]        cfg;
  logic [5:0]        cfg_shift;
  logic [CH_W-1:0]   low_new;
  logic [CH_W-1:0]   low_cur;
  logic [CH_W:0]     next_up;

  // Lowest enabled channel of a mask (0 when the mask is empty).
  function automatic logic [CH_W-1:0] first_ch(input logic [N_CH-1:0] m);
    first_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (m[k]) first_ch = CH_W'(k);
    end
  endfunction

  // Next enabled channel strictly above c; MSB of the result flags whether one exists.
  function automatic logic [CH_W:0] next_ch(input logic [N_CH-1:0] m, input logic [CH_W-1:0] c);
    next_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (m[k] && (k > int'(c))) next_ch = {1'b1, CH_W'(k)};
    end
  endfunction

  // Config word shifted out MSB first: single-ended, odd/sign, select1, select0, uni, no sleep.
  assign cfg = {1'b1, ch[0], ch[2], ch[1], uni_l, 1'b0};

  assign bus.busy       = busy;
  assign bus.out_valid  = out_valid;
  assign bus.out_ch     = out_ch;
  assign bus.out_data   = out_data;
  assign bus.adc_convst = convst;
  assign bus.adc_sck    = sck;
  assign bus.adc_sdi    = sdi;

  // Next-state, frame timing, channel sequencing and registered pin values.
  always_comb begin
    state_n      = state;
    fcnt_n       = fcnt + FCNT_W'(1);
    pcnt_n       = pcnt;
    bcnt_n       = bcnt;
    ch_n         = ch;
    mask_n       = mask;
    uni_n        = uni_l;
    cont_n       = cont;
    flush_n      = flush;
    prev_ch_n    = prev_ch;
    prev_valid_n = prev_valid;
    shreg_n      = shreg;
    out_valid_n  = 1'b0;
    out_ch_n     = out_ch;
    out_data_n   = out_data;
    sdi_n        = sdi;
    cfg_shift    = '0;
    low_new      = first_ch(bus.ch_mask);
    low_cur      = first_ch(mask);
    next_up      = next_ch(mask, ch);

    case (state)
      IDLE: begin
        fcnt_n       = '0;
        pcnt_n       = '0;
        bcnt_n       = '0;
        prev_valid_n = 1'b0;
        if ((bus.start || bus.run) && (|bus.ch_mask)) begin
          mask_n  = bus.ch_mask;
          uni_n   = bus.uni;
          cont_n  = bus.run;
          flush_n = 1'b0;
          ch_n    = low_new;
          state_n = CONVST;
        end
      end
      CONVST: begin
        if (fcnt == FCNT_W'(CONVST_CYC - 1)) state_n = CONV_WAIT;
      end
      CONV_WAIT: begin
        if (fcnt == FCNT_W'(CONV_CYC - 1)) begin
          state_n = SHIFT;
          pcnt_n  = '0;
          bcnt_n  = '0;
        end
      end
      SHIFT: begin
        if (pcnt == PCNT_W'(2 * SCK_HALF - 1)) begin
          pcnt_n  = '0;
          bcnt_n  = bcnt + BCNT_W'(1);
          shreg_n = {shreg[N_BITS-2:0], bus.adc_sdo};
          if (bcnt == BCNT_W'(N_BITS - 1)) begin
            state_n      = GAP;
            out_valid_n  = prev_valid;
            if (prev_valid) begin
              out_ch_n   = prev_ch;
              out_data_n = shreg_n;
            end
            prev_ch_n    = ch;
            prev_valid_n = 1'b1;
          end
        end else begin
          pcnt_n = pcnt + PCNT_W'(1);
        end
      end
      GAP: begin
        pcnt_n = '0;
        bcnt_n = '0;
        if (fcnt >= FCNT_W'(FRAME_CYC - 1)) begin
          fcnt_n  = '0;
          state_n = CONVST;
          if (flush) begin
            state_n      = IDLE;
            prev_valid_n = 1'b0;
          end else if (next_up[CH_W]) begin
            ch_n = next_up[CH_W-1:0];
          end else if (cont && bus.run) begin
            mask_n = bus.ch_mask;
            uni_n  = bus.uni;
            if (|bus.ch_mask) begin
              ch_n = low_new;
            end else begin
              ch_n    = low_cur;
              flush_n = 1'b1;
            end
          end else begin
            ch_n    = low_cur;
            flush_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        fcnt_n  = '0;
      end
    endcase

    convst_n = (state_n == CONVST);
    busy_n   = (state_n != IDLE);
    sck_n    = (state_n == SHIFT) && (pcnt_n >= PCNT_W'(SCK_HALF));
    if (state_n == SHIFT) begin
      if (pcnt_n == '0) begin
        cfg_shift = cfg << bcnt_n;
        sdi_n     = cfg_shift[5];
      end
    end else begin
      sdi_n = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset that aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fcnt       <= '0;
      pcnt       <= '0;
      bcnt       <= '0;
      ch         <= '0;
      mask       <= '0;
      uni_l      <= 1'b0;
      cont       <= 1'b0;
      flush      <= 1'b0;
      prev_ch    <= '0;
      prev_valid <= 1'b0;
      shreg      <= '0;
      convst     <= 1'b0;
      sck        <= 1'b0;
      sdi        <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
    end else begin
      state      <= state_n;
      fcnt       <= fcnt_n;
      pcnt       <= pcnt_n;
      bcnt       <= bcnt_n;
      ch         <= ch_n;
      mask       <= mask_n;
      uni_l      <= uni_n;
      cont       <= cont_n;
      flush      <= flush_n;
      prev_ch    <= prev_ch_n;
      prev_valid <= prev_valid_n;
      shreg      <= shreg_n;
      convst     <= convst_n;
      sck        <= sck_n;
      sdi        <= sdi_n;
      busy       <= busy_n;
      out_valid  <= out_valid_n;
      out_ch     <= out_ch_n;
      out_data   <= out_data_n;
    end
  end

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Bench for ltc2308_scan_ctrl: behavioural LTC2308 with one-frame config
// pipeline and pin timing checks, plus a result scoreboard.
// CONV_CYC is shortened so that a full frame fits inside FRAME_CYC.
module tb_ltc2308_scan_ctrl;

  localparam int N_CH       = 8;
  localparam int N_BITS     = 12;
  localparam int SCK_HALF   = 2;
  localparam int CONVST_CYC = 2;
  localparam int CONV_CYC   = 40;
  localparam int FRAME_CYC  = 100;
  localparam int PERIOD     = 10;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ltc2308_scan_ctrl_if #(.N_CH(N_CH), .N_BITS(N_BITS)) bus ();

  ltc2308_scan_ctrl #(
    .N_CH(N_CH), .N_BITS(N_BITS), .SCK_HALF(SCK_HALF),
    .CONVST_CYC(CONVST_CYC), .CONV_CYC(CONV_CYC), .FRAME_CYC(FRAME_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock.
  always #(PERIOD / 2) clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [11:0] ch_val [8] = '{12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC,
                              12'hBBB, 12'hAAA, 12'h999, 12'h888};

  int   convst_rises = 0;
  int   sck_edges = 0;
  int   out_count = 0;
  int   rise_base = 0;
  int   out_base = 0;
  int   first_out_frame = -1;
  logic exp_uni = 1'b0;

  logic [11:0] sdo_sh = '0;
  logic [5:0]  cfg_sh = '0;
  logic [5:0]  first_cfg = '0;
  logic [2:0]  conv_ch;
  int          sck_cnt = 0;
  logic        aborted = 1'b1;
  logic        have_frame = 1'b0;
  logic        convst_q = 1'b0;
  logic        sck_q = 1'b0;
  time         t_rise = 0;

  assign bus.adc_sdo = sdo_sh[11];

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] c, input logic [11:0] d);
    exp_q.push_back({c, d});
  endtask

  task automatic begin_test();
    rise_base = convst_rises;
    out_base  = out_count;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while ((convst_rises - rise_base) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_value("wait_frames", convst_rises - rise_base, n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!bus.busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    while (bus.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_value("idle_reached", bus.busy, 0);
  endtask

  // LTC2308 model: config shifted in on SCK rise, conversion on CONVST rise
  // uses the previous frame's config, result shifted out on SCK fall.
  always @(bus.adc_convst or bus.adc_sck or rst) begin
    if (rst) aborted = 1'b1;
    if (bus.adc_convst === 1'b1 && convst_q === 1'b0) begin
      if (have_frame && !aborted) check_value("sck_per_frame", sck_cnt, N_BITS);
      if ((convst_rises - rise_base) > 0 && !aborted)
        check_value("convst_period", int'(($time - t_rise) / PERIOD), FRAME_CYC);
      conv_ch      = {cfg_sh[3], cfg_sh[2], cfg_sh[4]};
      sdo_sh       = ch_val[conv_ch];
      aborted      = 1'b0;
      have_frame   = 1'b1;
      t_rise       = $time;
      sck_cnt      = 0;
      convst_rises = convst_rises + 1;
    end
    if (bus.adc_sck === 1'b1 && sck_q === 1'b0) begin
      sck_cnt   = sck_cnt + 1;
      sck_edges = sck_edges + 1;
      if (sck_cnt == 1 && !aborted)
        check_value("tconv", int'(($time - t_rise) / PERIOD), CONV_CYC + SCK_HALF);
      if (sck_cnt <= 6) cfg_sh = {cfg_sh[4:0], bus.adc_sdi};
      if (sck_cnt == 6) begin
        if ((convst_rises - rise_base) == 1) first_cfg = cfg_sh;
        check_value("cfg_single_ended", cfg_sh[5], 1);
        check_value("cfg_sleep", cfg_sh[0], 0);
        check_value("cfg_uni", cfg_sh[1], exp_uni);
      end
    end else if (bus.adc_sck === 1'b0 && sck_q === 1'b1) begin
      sdo_sh = {sdo_sh[10:0], 1'b0};
    end
    convst_q = bus.adc_convst;
    sck_q    = bus.adc_sck;
  end

  // Scoreboard monitor: every result strobe pops one expected (channel, data) pair.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid === 1'b1) begin
      if (out_count == out_base) first_out_frame = convst_rises - rise_base;
      out_count = out_count + 1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got ch%0d data %0h, expected none", bus.out_ch, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check_value("out_ch", bus.out_ch, e.ch);
        check_value("out_data", bus.out_data, e.data);
      end
    end
  end

  // Hard stop in case the sequence below stalls.
  initial begin
    #(1_000_000);
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    int busy_seen;
    int rise0;
    int edge0;
    bus.start   = 1'b0;
    bus.run     = 1'b0;
    bus.ch_mask = '0;
    bus.uni     = 1'b0;

    // Reset: hold 5 cycles, all outputs low, then no convst for 20 cycles.
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_value("rst_convst", bus.adc_convst, 0);
    check_value("rst_sck", bus.adc_sck, 0);
    check_value("rst_sdi", bus.adc_sdi, 0);
    check_value("rst_busy", bus.busy, 0);
    check_value("rst_out_valid", bus.out_valid, 0);
    check_value("rst_out_ch", bus.out_ch, 0);
    check_value("rst_out_data", bus.out_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    rise0 = convst_rises;
    repeat (20) @(posedge clk);
    check_value("no_convst_after_reset", convst_rises - rise0, 0);

    // Single sweep over CH0 and CH2, unipolar.
    begin_test();
    exp_uni = 1'b1;
    bus.uni = 1'b1;
    bus.ch_mask = 8'h05;
    push_exp(3'd0, 12'hFFF);
    push_exp(3'd2, 12'hDDD);
    pulse_start();
    wait_idle(8 * FRAME_CYC);
    check_value("sweep05_frames", convst_rises - rise_base, 3);
    check_value("sweep05_first_out_frame", first_out_frame, 2);
    check_value("sweep05_queue_empty", exp_q.size(), 0);
    check_value("sweep05_cfg", first_cfg, 6'b100010);

    // Single sweep over CH5: SDI word 1,1,1,0,1,0.
    begin_test();
    bus.ch_mask = 8'h20;
    push_exp(3'd5, 12'hAAA);
    pulse_start();
    wait_idle(6 * FRAME_CYC);
    check_value("sweep20_frames", convst_rises - rise_base, 2);
    check_value("sweep20_cfg", first_cfg, 6'b111010);
    check_value("sweep20_queue_empty", exp_q.size(), 0);

    // Continuous sweep of all channels, bipolar; run drops after 20 frames.
    begin_test();
    exp_uni = 1'b0;
    bus.uni = 1'b0;
    bus.ch_mask = 8'hFF;
    for (int k = 0; k < 24; k++) push_exp(3'(k % 8), ch_val[k % 8]);
    @(posedge clk); #1 bus.run = 1'b1;
    wait_frames(20, 22 * FRAME_CYC);
    #1 bus.run = 1'b0;
    wait_idle(8 * FRAME_CYC);
    check_value("run_frames", convst_rises - rise_base, 25);
    check_value("run_first_out_frame", first_out_frame, 2);
    check_value("run_queue_empty", exp_q.size(), 0);

    // Empty mask: start does nothing on the pins.
    begin_test();
    bus.ch_mask = 8'h00;
    rise0 = convst_rises;
    edge0 = sck_edges;
    busy_seen = 0;
    pulse_start();
    repeat (50) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    check_value("mask0_busy", busy_seen, 0);
    check_value("mask0_convst", convst_rises - rise0, 0);
    check_value("mask0_sck", sck_edges - edge0, 0);

    // Reset in the middle of the second frame's shift phase.
    begin_test();
    exp_uni = 1'b1;
    bus.uni = 1'b1;
    bus.ch_mask = 8'h03;
    pulse_start();
    wait_frames(2, 4 * FRAME_CYC);
    repeat (CONV_CYC + 20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_value("abort_busy", bus.busy, 0);
    check_value("abort_convst", bus.adc_convst, 0);
    check_value("abort_sck", bus.adc_sck, 0);
    check_value("abort_sdi", bus.adc_sdi, 0);
    check_value("abort_out_ch", bus.out_ch, 0);
    check_value("abort_out_data", bus.out_data, 0);
    check_value("abort_queue_empty", exp_q.size(), 0);

    // Restart with CH0 only.
    begin_test();
    bus.ch_mask = 8'h01;
    push_exp(3'd0, 12'hFFF);
    pulse_start();
    wait_idle(6 * FRAME_CYC);
    check_value("restart_frames", convst_rises - rise_base, 2);
    check_value("restart_first_out_frame", first_out_frame, 2);
    check_value("restart_queue_empty", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
